// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned WORD_STRIDE = 4;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam int unsigned       DEFAULT_MAX_WORDS = 256;

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2^32 sum of accepted program words.
module loader_checksum
  import mips_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, then releases the CPU from reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (sum check before RUN).
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned       MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               halt,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               mem_write_enabled,
  output logic [WORD_W-1:0]  mem_address,
  output logic [WORD_W-1:0]  mem_data,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
  input  logic [WORD_W-1:0]  expected_sum,
  output logic               err_checksum
);

  state_e             state;
  logic [WORD_W-1:0]  waddr;
  logic [COUNT_W-1:0] beat_cnt;
  logic [COUNT_W-1:0] wc_reg;

  logic too_long_c;
  logic load_start_c;
  logic beat_c;
  logic chk_fail_c;

  assign too_long_c   = 32'(word_count) > MAX_WORDS;
  assign load_start_c = (state == IDLE) && start && (word_count != '0) && !too_long_c;
  assign beat_c       = (state == LOAD) && in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] run_sum;
  logic              err_chk_q;

  loader_checksum u_checksum (
    .clock  (clock),
    .reset  (reset),
    .clear  (load_start_c),
    .add_en (beat_c),
    .word   (in_data),
    .sum    (run_sum)
  );

  assign chk_fail_c = (run_sum != expected_sum);

  // Sticky until reset or the next accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_chk_q <= 1'b0;
    end else if ((state == IDLE) && start && !too_long_c) begin
      err_chk_q <= 1'b0;
    end else if ((state == DRAIN) && chk_fail_c) begin
      err_chk_q <= 1'b1;
    end
  end

  assign err_checksum = err_chk_q;
`else
  logic unused_expected_sum;
  assign unused_expected_sum = ^expected_sum;
  assign chk_fail_c          = 1'b0;
  assign err_checksum        = 1'b0;
`endif

  // Control FSM; every status output is updated alongside the state it reflects.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      waddr             <= '0;
      beat_cnt          <= '0;
      wc_reg            <= '0;
      in_ready          <= 1'b0;
      mem_write_enabled <= 1'b0;
      mem_address       <= '0;
      mem_data          <= '0;
      cpu_reset         <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_overflow      <= 1'b0;
    end else begin
      mem_write_enabled <= 1'b0;
      err_overflow      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else if (too_long_c) begin
              err_overflow <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              waddr    <= BASE_ADDR;
              beat_cnt <= '0;
              wc_reg   <= word_count;
            end
          end
        end
        LOAD: begin
          if (beat_c) begin
            mem_write_enabled <= 1'b1;
            mem_address       <= waddr;
            mem_data          <= in_data;
            waddr             <= waddr + WORD_W'(WORD_STRIDE);
            beat_cnt          <= beat_cnt + COUNT_W'(1);
            if ((beat_cnt + COUNT_W'(1)) == wc_reg) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          busy <= 1'b0;
          if (chk_fail_c) begin
            state <= IDLE;
          end else begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-list write model.
module tb_imem_loader;
  import mips_loader_pkg::*;

  localparam logic [31:0] BASE = DEFAULT_BASE_ADDR;
  localparam int unsigned MAXW = DEFAULT_MAX_WORDS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] word_count = '0;
  logic [31:0] in_data = '0;
  logic [31:0] expected_sum = '0;
  logic        in_ready, mem_write_enabled, cpu_reset, busy, done, err_overflow, err_checksum;
  logic [31:0] mem_address, mem_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .word_count        (word_count),
    .halt              (halt),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .mem_write_enabled (mem_write_enabled),
    .mem_address       (mem_address),
    .mem_data          (mem_data),
    .cpu_reset         (cpu_reset),
    .busy              (busy),
    .done              (done),
    .err_overflow      (err_overflow),
    .expected_sum      (expected_sum),
    .err_checksum      (err_checksum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Log every memory write with the cycle it appeared in.
  always @(negedge clock) begin
    if (mem_write_enabled === 1'b1) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic go_idle();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  // Issue start and stream the words; returns right after the last beat is accepted.
  task automatic run_load(input logic [31:0] words[$], input int gap_lo, input int gap_hi,
                          input bit noise, input logic [31:0] sum_xor);
    logic [31:0] s;
    s = '0;
    foreach (words[i]) s += words[i];
    expected_sum = s ^ sum_xor;
    start = 1'b1;
    word_count = 16'(words.size());
    tick();
    start = 1'b0;
    foreach (words[i]) begin
      int gap;
      gap = int'($urandom_range(gap_hi, gap_lo));
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          start = 1'($urandom);
          halt = 1'($urandom);
          word_count = 16'($urandom);
          in_data = $urandom;
        end
        tick();
      end
      start = 1'b0;
      halt = 1'b0;
      for (int t = 0; t < 20 && in_ready !== 1'b1; t++) tick();
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_timeout beat %0d: in_ready=%b, required 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data = words[i];
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if ({cpu_reset, in_ready, mem_write_enabled, busy, done, err_overflow, err_checksum} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 1000000",
               {cpu_reset, in_ready, mem_write_enabled, busy, done, err_overflow, err_checksum});
    end
    vectors++;
    if (mem_address !== 32'h0 || mem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h data=%h, required 0 0", mem_address, mem_data);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h11, 32'h22, 32'h33};
    clear_log();
    run_load(w, 0, 0, 1'b0, 32'h0);
    vectors++;
    if (mem_write_enabled !== 1'b1 || mem_address !== BASE + 32'd8 || mem_data !== 32'h33) begin
      miscompares++;
      $display("FAIL basic_drain_write: we=%b addr=%h data=%h, required 1 %h 33",
               mem_write_enabled, mem_address, mem_data, BASE + 32'd8);
    end
    vectors++;
    if ({busy, cpu_reset, in_ready, done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL basic_drain_flags: got %b, required 1100", {busy, cpu_reset, in_ready, done});
    end
    tick();
    vectors++;
    if ({busy, cpu_reset, done, mem_write_enabled} !== 4'b0010) begin
      miscompares++;
      $display("FAIL basic_run_flags: got %b, required 0010", {busy, cpu_reset, done, mem_write_enabled});
    end
    vectors++;
    if (wr_addr_q.size() != 3) begin
      miscompares++;
      $display("FAIL basic_count: got %0d writes, required 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i] || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
          miscompares++;
          $display("FAIL basic_write%0d: addr=%h data=%h cyc+%0d, required %h %h +%0d",
                   i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i] - wr_cyc_q[0], BASE + 32'(4 * i), w[i], i);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_gap();
    logic [31:0] w[$];
    w = '{32'hCAFE_0001, 32'hCAFE_0002};
    clear_log();
    run_load(w, 2, 2, 1'b0, 32'h0);
    tick();
    tick();
    vectors++;
    if (wr_addr_q.size() != 2) begin
      miscompares++;
      $display("FAIL gap_count: got %0d writes, required 2", wr_addr_q.size());
    end else begin
      vectors++;
      if (wr_addr_q[0] !== BASE || wr_addr_q[1] !== BASE + 32'd4 || wr_data_q[0] !== w[0] ||
          wr_data_q[1] !== w[1] || wr_cyc_q[1] - wr_cyc_q[0] != 3) begin
        miscompares++;
        $display("FAIL gap_writes: %h/%h %h/%h spacing %0d, required %h/%h %h/%h 3",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], wr_cyc_q[1] - wr_cyc_q[0],
                 BASE, w[0], BASE + 32'd4, w[1]);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_done: done=%b, required 1", done);
    end
    go_idle();
  endtask

  task automatic test_overflow();
    int wcs[2];
    wcs[0] = 257;
    wcs[1] = 65535;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      word_count = 16'(wcs[k]);
      tick();
      start = 1'b0;
      vectors++;
      if ({err_overflow, in_ready, busy, cpu_reset, done} !== 5'b10010) begin
        miscompares++;
        $display("FAIL ovf_pulse wc=%0d: got %b, required 10010", wcs[k],
                 {err_overflow, in_ready, busy, cpu_reset, done});
      end
      tick();
      vectors++;
      if ({err_overflow, in_ready, busy, done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL ovf_after wc=%0d: got %b, required 0000", wcs[k], {err_overflow, in_ready, busy, done});
      end
    end
    clear_log();
    start = 1'b1;
    word_count = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, cpu_reset, busy, in_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL zero_len_run: got %b, required 1000", {done, cpu_reset, busy, in_ready});
    end
    tick();
    tick();
    vectors++;
    if (wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes: got %0d writes, required 0", wr_addr_q.size());
    end
    go_idle();
  endtask

  task automatic test_max();
    logic [31:0] w[$];
    int bad;
    for (int i = 0; i < int'(MAXW); i++) w.push_back($urandom);
    clear_log();
    run_load(w, 0, 0, 1'b0, 32'h0);
    tick();
    vectors++;
    if (done !== 1'b1 || wr_addr_q.size() != int'(MAXW)) begin
      miscompares++;
      $display("FAIL max_len: done=%b writes=%0d, required 1 %0d", done, wr_addr_q.size(), MAXW);
    end else begin
      bad = 0;
      for (int i = 0; i < int'(MAXW); i++)
        if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL max_len_writes: %0d wrong writes, required 0", bad);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    start = 1'b1;
    word_count = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA1A1_A1A1;
    tick();
    in_data = 32'hA2A2_A2A2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if ({mem_write_enabled, in_ready, busy, cpu_reset, done} !== 5'b00010 || mem_address !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_state: flags=%b addr=%h, required 00010 0",
               {mem_write_enabled, in_ready, busy, cpu_reset, done}, mem_address);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b0 || mem_write_enabled !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: in_ready=%b we=%b, required 0 0", in_ready, mem_write_enabled);
    end
    clear_log();
    w = '{32'hB1B1_B1B1};
    run_load(w, 0, 0, 1'b0, 32'h0);
    tick();
    vectors++;
    if (wr_addr_q.size() != 1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_reload: writes=%0d done=%b, required 1 1", wr_addr_q.size(), done);
    end else begin
      vectors++;
      if (wr_addr_q[0] !== BASE || wr_data_q[0] !== w[0]) begin
        miscompares++;
        $display("FAIL midreset_write: %h/%h, required %h/%h", wr_addr_q[0], wr_data_q[0], BASE, w[0]);
      end
    end
    go_idle();
  endtask

  task automatic test_halt();
    logic [31:0] w[$];
    halt = 1'b1;
    tick();
    halt = 1'b0;
    vectors++;
    if ({cpu_reset, done, in_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL halt_in_idle: got %b, required 100", {cpu_reset, done, in_ready});
    end
    start = 1'b1;
    word_count = 16'd0;
    tick();
    word_count = 16'd5;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, cpu_reset, in_ready, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL start_in_run: got %b, required 1000", {done, cpu_reset, in_ready, busy});
    end
    go_idle();
    vectors++;
    if ({cpu_reset, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL halt_run: got %b, required 10", {cpu_reset, done});
    end
    clear_log();
    w = '{$urandom, $urandom};
    run_load(w, 0, 1, 1'b0, 32'h0);
    tick();
    vectors++;
    if (done !== 1'b1 || wr_data_q.size() != 2) begin
      miscompares++;
      $display("FAIL halt_restart: done=%b writes=%0d, required 1 2", done, wr_data_q.size());
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [31:0] w[$];
      int n;
      int bad;
      n = int'($urandom_range(8, 1));
      for (int i = 0; i < n; i++) w.push_back($urandom);
      clear_log();
      run_load(w, 0, 3, 1'b1, 32'h0);
      vectors++;
      if (mem_write_enabled !== 1'b1 || mem_data !== w[n-1] || mem_address !== BASE + 32'(4 * (n - 1))) begin
        miscompares++;
        $display("FAIL rand%0d_last: we=%b addr=%h data=%h, required 1 %h %h", it,
                 mem_write_enabled, mem_address, mem_data, BASE + 32'(4 * (n - 1)), w[n-1]);
      end
      tick();
      bad = (wr_addr_q.size() != n) ? 1 : 0;
      if (bad == 0)
        for (int i = 0; i < n; i++)
          if (wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i]) bad++;
      vectors++;
      if (bad != 0 || done !== 1'b1 || cpu_reset !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_writes: writes=%0d bad=%0d done=%b cpu_reset=%b, required %0d 0 1 0",
                 it, wr_addr_q.size(), bad, done, cpu_reset, n);
      end
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
        start = 1'($urandom);
        word_count = 16'($urandom);
        tick();
        vectors++;
        if ({done, in_ready, mem_write_enabled} !== 3'b100) begin
          miscompares++;
          $display("FAIL rand%0d_run_hold: got %b, required 100", it, {done, in_ready, mem_write_enabled});
        end
      end
      start = 1'b0;
      go_idle();
      vectors++;
      if (cpu_reset !== 1'b1) begin
        miscompares++;
        $display("FAIL rand%0d_halt: cpu_reset=%b, required 1", it, cpu_reset);
      end
    end
  endtask

  task automatic test_checksum();
    logic [31:0] w[$];
    w = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_load(w, 0, 0, 1'b0, 32'h0);
    tick();
    vectors++;
    if ({done, cpu_reset, err_checksum} !== 3'b100 || expected_sum !== 32'h1) begin
      miscompares++;
      $display("FAIL sum_good: got %b (expected_sum %h), required 100 (1)",
               {done, cpu_reset, err_checksum}, expected_sum);
    end
    go_idle();
    run_load(w, 0, 0, 1'b0, 32'h2);
    tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if ({done, cpu_reset, err_checksum, in_ready, busy} !== 5'b01100) begin
      miscompares++;
      $display("FAIL sum_bad: got %b, required 01100", {done, cpu_reset, err_checksum, in_ready, busy});
    end
    tick();
    vectors++;
    if (err_checksum !== 1'b1) begin
      miscompares++;
      $display("FAIL sum_sticky: err_checksum=%b, required 1", err_checksum);
    end
    start = 1'b1;
    word_count = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if ({err_checksum, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL sum_clear: got %b, required 01", {err_checksum, done});
    end
`else
    vectors++;
    if ({done, cpu_reset, err_checksum} !== 3'b100) begin
      miscompares++;
      $display("FAIL sum_ignored: got %b, required 100", {done, cpu_reset, err_checksum});
    end
`endif
    go_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_max();
    test_reset_mid();
    test_halt();
    test_random();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning the largest accepted program length in words.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a single-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port word_count, input, 16, the program length in words, sampled with start.
REQ-007 SHALL have port halt, input, 1, which stops the CPU and returns the block to IDLE, sampled only in RUN.
REQ-008 SHALL have ports in_valid (input, 1), in_data (input, 32) and in_ready (output, 1), forming the program word stream.
REQ-009 SHALL have ports mem_write_enabled (output, 1), mem_address (output, 32) and mem_data (output, 32), driving the instruction memory write port.
REQ-010 SHALL have port cpu_reset, output, 1, which holds the pc and CPU in reset while high.
REQ-011 SHALL have ports busy (output, 1), done (output, 1) and err_overflow (output, 1).
REQ-012 SHALL have ports expected_sum (input, 32) and err_checksum (output, 1); both are used only under REQ-031.

Function
REQ-013 SHALL implement the states IDLE, LOAD, DRAIN and RUN.
REQ-014 In IDLE, start with word_count==0 SHALL go to RUN on the next cycle with no memory write.
REQ-015 In IDLE, start with word_count>MAX_WORDS SHALL pulse err_overflow for 1 cycle and remain in IDLE.
REQ-016 In IDLE, start with 1<=word_count<=MAX_WORDS SHALL go to LOAD; the write address is set to BASE_ADDR and the beat counter is cleared.
REQ-017 in_ready SHALL be 1 exactly when the state is LOAD; a beat is accepted when in_valid and in_ready are both high.
REQ-018 On each accepted beat, the next cycle SHALL drive mem_write_enabled=1, mem_address=current write address and mem_data=the accepted word (1-cycle registered latency).
REQ-019 On each accepted beat, the write address SHALL increase by 4, wrapping modulo 2^32; the beat counter SHALL increase by 1.
REQ-020 mem_write_enabled SHALL be 0 in every cycle that does not follow an accepted beat; in_valid low SHALL insert idle cycles without losing data.
REQ-021 Acceptance of beat number word_count SHALL move the block from LOAD to DRAIN; DRAIN lasts exactly 1 cycle, during which the last write is issued.
REQ-022 DRAIN SHALL go to RUN, except under the failing-checksum condition of REQ-031.
REQ-023 cpu_reset SHALL be 0 only in RUN, so the CPU first fetches the cycle after the last write.
REQ-024 done SHALL be 1 only in RUN; busy SHALL be 1 in LOAD and DRAIN.
REQ-025 halt in RUN SHALL go to IDLE with cpu_reset=1 on the next cycle.
REQ-026 start outside IDLE and halt outside RUN SHALL be ignored.

Reset
REQ-027 reset SHALL take precedence over all inputs, including a reset arriving mid-LOAD or mid-DRAIN; any pending write is discarded.
REQ-028 After reset the block SHALL be in IDLE with cpu_reset=1 and in_ready=0, mem_write_enabled=0, mem_address=0, mem_data=0, busy=0, done=0, err_overflow=0 and err_checksum=0, and the running sum SHALL be 0.

Configuration
REQ-029 The feature macro SHALL be IMEM_LOADER_CHECKSUM_EN.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, err_checksum SHALL be tied to 0, expected_sum SHALL be ignored, and DRAIN SHALL always go to RUN.
REQ-031 With IMEM_LOADER_CHECKSUM_EN:
- a running 32-bit sum (modulo 2^32) of the accepted words is kept, cleared on entry to LOAD;
- in DRAIN the sum is compared with expected_sum; on mismatch the block goes to IDLE, cpu_reset stays 1, and err_checksum is set;
- err_checksum is sticky until reset or the next accepted start.

Structure
REQ-032 The shared package mips_loader_pkg SHALL hold the state enumeration, the WORD_STRIDE=4 constant and the default BASE_ADDR and MAX_WORDS.
REQ-033 The running sum SHALL be one sub-module, loader_checksum, instantiated only under IMEM_LOADER_CHECKSUM_EN; all other logic SHALL be flat.

Verification
REQ-034 Load with word_count=3, words 0x11, 0x22, 0x33 and in_valid always high -> writes to 0x0, 0x4 and 0x8 on consecutive cycles, one DRAIN cycle, then cpu_reset=0.
REQ-035 Load with word_count=2 and a 2-cycle in_valid gap between the beats -> exactly 2 writes, no spurious mem_write_enabled, addresses 0x0 and 0x4.
REQ-036 start with word_count=257 and MAX_WORDS=256 -> 1-cycle err_overflow pulse, state stays IDLE; then start with word_count=0 -> RUN with no writes.
REQ-037 reset asserted after beat 1 of 4, then a fresh load of 1 word -> write to BASE_ADDR, no residue from the aborted load.
REQ-038 With the macro, words 0xFFFFFFFF and 0x2 and expected_sum=0x1 -> RUN; the same words with expected_sum=0x3 -> err_checksum=1, IDLE, cpu_reset=1.
REQ-039 halt in RUN -> cpu_reset=1 the next cycle; a subsequent start is accepted.
